pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Reset and clock-enable sequencer sitting directly downstream of the ECP5 PLL that turns the 25 MHz board clock into the 48 MHz USB clock. Runs in the 48 MHz domain, synchronises the PLL `locked` flag, holds the design in reset until lock has been stable for a programmable time, and then releases a clean system reset. Once running, it generates the 12 MHz full-speed USB bit-rate clock enable. It also counts lock-loss events for debug.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `locked` synchroniser (≥2).
- `LOCK_CYCLES`, 4800: consecutive clean-lock cycles required before release (100 µs at 48 MHz; ≥1).
- `CE_DIV`, 4: `clk` cycles per `ce_12m` pulse (≥2).

Ports:
- `clk`: input, 1 bit. 48 MHz PLL output clock. Single clock domain.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `locked`: input, 1 bit. PLL lock flag. Asynchronous to `clk`.
- `sys_rst`: output, 1 bit. Active-high system reset for the 48 MHz domain.
- `ready`: output, 1 bit. High while in RUN; equal to `~sys_rst`.
- `ce_12m`: output, 1 bit. Single-cycle clock-enable pulse every `CE_DIV` cycles; asserted only in RUN.
- `lost_cnt`: output, 8 bits. Saturating count of lock losses observed while in RUN.

## Operation
- **Synchroniser.** `locked` passes through a `SYNC_STAGES`-flop chain; the last stage is `locked_s`. All flops clear on `rst`.
- **FSM states:** WAIT_LOCK, STABLE, RUN.
- **Reset values** (`rst` high):
  - State is WAIT_LOCK; stability counter is 0; divider is 0; `lost_cnt` is 0; synchroniser is all 0.
  - Outputs: `sys_rst`=1, `ready`=0, `ce_12m`=0.
- **WAIT_LOCK:** when `locked_s`=1, go to STABLE and clear the counter.
- **STABLE:**
  - If `locked_s`=0, go to WAIT_LOCK. This is a glitch during qualification; `lost_cnt` is not incremented.
  - Otherwise, if counter = `LOCK_CYCLES`−1, go to RUN; else increment the counter.
- **RUN:** if `locked_s`=0, go to WAIT_LOCK and increment `lost_cnt`, saturating at 255 (255 holds).
- **Output decodes:**
  - `sys_rst` = (state ≠ RUN). `ready` = (state = RUN).
  - Both decode directly from the state register, with no extra combinational inputs.
- **Clock enable:**
  - The divider counts 0..`CE_DIV`−1 and wraps, only while in RUN.
  - The divider is forced to 0 in every other state.
  - `ce_12m` = RUN && divider = 0, so the first RUN cycle carries a pulse.
- **Counter widths:**
  - Stability counter is `$clog2(LOCK_CYCLES)` bits, minimum 1.
  - Divider is `$clog2(CE_DIV)` bits.
- **`rst` during any state:** the FSM returns to WAIT_LOCK on the next edge, and `lost_cnt` clears. `rst` has priority over every transition.

## Timing
- Let `locked` rise before edge 1 and stay high. Then:
  - `locked_s` goes high after edge `SYNC_STAGES`.
  - The FSM enters STABLE at edge `SYNC_STAGES`+1.
  - The FSM enters RUN, with `sys_rst` low, at edge `SYNC_STAGES`+1+`LOCK_CYCLES`.
- Lock loss in RUN: `locked` falls before edge 1. Then, at edge `SYNC_STAGES`+1:
  - `sys_rst`=1 and `ce_12m` stops.
  - `lost_cnt` increments.
- `ce_12m` period is exactly `CE_DIV` cycles with a duty of 1/`CE_DIV`. There are no pulses outside RUN.
- A `locked` low pulse shorter than one clock may or may not be seen. If seen, it is handled as above.

## Structure
- Shared package/include `pll_reset_pkg`:
  - State encoding constants (WAIT_LOCK=0, STABLE=1, RUN=2).
  - `LOST_CNT_W`=8.
- Sub-module `sync_ff`: parameterised `SYNC_STAGES`-deep single-bit synchroniser with synchronous active-high clear. Reusable for other crossings.
- The FSM, stability counter, divider and `lost_cnt` all live in `pll_reset_seq`.

## Test plan
All scenarios use `SYNC_STAGES`=2, `LOCK_CYCLES`=4, `CE_DIV`=4.

1. **Reset values.** Hold `rst` for 3 cycles with `locked`=1. Required: `sys_rst`=1, `ready`=0, `ce_12m`=0 and `lost_cnt`=0 throughout the reset.
2. **Clean lock.** Release `rst` with `locked`=1. Required:
   - `sys_rst` falls exactly 7 edges after `locked` is first sampled.
   - `ce_12m` pulses on the first RUN cycle, then every 4th cycle.
3. **Qualification glitch.** Drop `locked` low for 1 cycle during STABLE. Required:
   - The FSM returns to WAIT_LOCK and the stability count restarts.
   - `lost_cnt` stays 0.
   - `sys_rst` stays high until a full 4-cycle window passes.
4. **Loss in RUN.** Drop `locked` while in RUN. Required:
   - `sys_rst`=1 and `ce_12m` stops 3 edges later.
   - `lost_cnt`=1.
   - Relocking releases `sys_rst` after another 7 edges.
5. **Saturation.** Force 260 loss/relock cycles. Required: `lost_cnt` reaches 255 and holds there.
6. **Mid-operation reset.** Assert `rst` in RUN with `lost_cnt`=3. Required:
   - On the next edge: `sys_rst`=1, `ce_12m`=0, `lost_cnt`=0.
   - Full resequencing after `rst` is released.

Source files
------------

// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer: FSM state encoding,
// lock-loss counter width and a saturating increment helper.
package pll_reset_pkg;

  localparam int LOST_CNT_W = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser with synchronous active-high clear.
// Reusable for any slow level signal crossing into the clk domain.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // NOTE: non-blocking assignments make every stage sample its neighbour's
  // pre-edge value, so the chain shifts by exactly one flop per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Holds the 48 MHz domain in reset until PLL lock has been stable for
// LOCK_CYCLES cycles, then generates the 12 MHz enable and counts lock losses.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 4800,
  parameter int CE_DIV      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  ce_12m,
  output logic [LOST_CNT_W-1:0] lost_cnt
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int DIV_W = $clog2(CE_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

  logic             locked_s;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] stab_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             stab_done;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  assign stab_done = (stab_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_LOCK;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is defaulted before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) state_next = STABLE;
      end
      STABLE: begin
        if (!locked_s)     state_next = WAIT_LOCK;
        else if (stab_done) state_next = RUN;
      end
      RUN: begin
        if (!locked_s) state_next = WAIT_LOCK;
      end
      default: state_next = WAIT_LOCK;
    endcase
  end

  always_comb begin
    sys_rst = 1'b1;
    ready   = 1'b0;
    ce_12m  = 1'b0;
    if (state == RUN) begin
      sys_rst = 1'b0;
      ready   = 1'b1;
      ce_12m  = (div_cnt == '0);
    end
  end

  // Counts clean-lock cycles in STABLE; any other situation restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (state == STABLE && locked_s && !stab_done) begin
      stab_cnt <= stab_cnt + 1'b1;
    end else begin
      stab_cnt <= '0;
    end
  end

  // Held at zero outside RUN so the first RUN cycle always carries a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (state == RUN) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end else begin
      div_cnt <= '0;
    end
  end

  // Only losses after release count; glitches during qualification do not.
  always_ff @(posedge clk) begin
    if (rst) begin
      lost_cnt <= '0;
    end else if (state == RUN && !locked_s) begin
      lost_cnt <= sat_inc(lost_cnt);
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: constant vectors, directed corner
// sequences and randomized stimulus against a lock-streak reference model.
module tb_pll_reset_seq;

  localparam int SYNC = 2;
  localparam int LOCK = 4;
  localparam int DIV  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       sys_rst;
  logic       ready;
  logic       ce_12m;
  logic [7:0] lost_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pll_reset_seq #(
    .SYNC_STAGES (SYNC),
    .LOCK_CYCLES (LOCK),
    .CE_DIV      (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .locked   (locked),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .ce_12m   (ce_12m),
    .lost_cnt (lost_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the design is released once the synchronised lock flag
  // has been seen high on LOCK+1 consecutive edges; the enable phase is the
  // streak length past that point modulo DIV.
  bit hist [SYNC];
  int streak = 0;
  int m_lost = 0;

  always @(posedge clk) begin
    bit ls;
    bit was_ready;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
      streak = 0;
      m_lost = 0;
    end else begin
      ls        = hist[SYNC-1];
      was_ready = (streak >= LOCK + 1);
      streak    = ls ? streak + 1 : 0;
      if (was_ready && !ls && m_lost < 255) m_lost = m_lost + 1;
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = locked;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit m_ready;
    bit m_ce;
    m_ready = (streak >= LOCK + 1);
    m_ce    = m_ready && (((streak - (LOCK + 1)) % DIV) == 0);
    check("model_ready",   {31'd0, ready},    {31'd0, m_ready});
    check("model_sys_rst", {31'd0, sys_rst},  {31'd0, !m_ready});
    check("model_ce",      {31'd0, ce_12m},   {31'd0, m_ce});
    check("model_lost",    {24'd0, lost_cnt}, m_lost);
  endtask

  task automatic step(input logic r, input logic l);
    @(negedge clk);
    rst    = r;
    locked = l;
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Drives locked high and counts edges until release; -1 if it never comes.
  task automatic wait_ready(input string name, input int exp_edges);
    int n;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1);
      if (ready === 1'b1) begin
        n = i;
        break;
      end
    end
    check(name, n, exp_edges);
  endtask

  typedef struct {
    logic       rst;
    logic       locked;
    logic       sys_rst;
    logic       ready;
    logic       ce;
    logic [7:0] lost;
  } vec_t;

  vec_t vecs [15];

  initial begin
    // Reset for 3 cycles, then a clean lock: release on the 7th edge,
    // enable pulse on the first RUN cycle and every 4th after.
    for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    for (int i = 3; i < 9; i++) vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].locked);
      check($sformatf("vec%0d_sys_rst", i), {31'd0, sys_rst}, {31'd0, vecs[i].sys_rst});
      check($sformatf("vec%0d_ready", i),   {31'd0, ready},   {31'd0, vecs[i].ready});
      check($sformatf("vec%0d_ce", i),      {31'd0, ce_12m},  {31'd0, vecs[i].ce});
      check($sformatf("vec%0d_lost", i),    {24'd0, lost_cnt}, {24'd0, vecs[i].lost});
    end

    // Qualification glitch: 1-cycle low while in STABLE restarts the window.
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    wait_ready("glitch_release_edges", 7);
    check("glitch_lost", {24'd0, lost_cnt}, 32'd0);

    // Lock loss in RUN: release drops on the 3rd edge, counter bumps.
    step(1'b0, 1'b0);
    check("loss_e1_sys_rst", {31'd0, sys_rst}, 32'd0);
    step(1'b0, 1'b0);
    check("loss_e2_sys_rst", {31'd0, sys_rst}, 32'd0);
    step(1'b0, 1'b0);
    check("loss_e3_sys_rst", {31'd0, sys_rst}, 32'd1);
    check("loss_e3_ce",      {31'd0, ce_12m},  32'd0);
    check("loss_e3_lost",    {24'd0, lost_cnt}, 32'd1);
    wait_ready("relock_edges", 7);

    // Two more losses, then reset in RUN with lost_cnt = 3.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      wait_ready("relock_k_edges", 7);
    end
    step(1'b0, 1'b1);
    check("pre_rst_lost", {24'd0, lost_cnt}, 32'd3);
    step(1'b1, 1'b1);
    check("midrst_sys_rst", {31'd0, sys_rst}, 32'd1);
    check("midrst_ce",      {31'd0, ce_12m},  32'd0);
    check("midrst_lost",    {24'd0, lost_cnt}, 32'd0);
    wait_ready("midrst_reseq_edges", 7);

    // Saturation: 260 loss/relock cycles.
    for (int k = 0; k < 260; k++) begin
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      check("sat_lost", {24'd0, lost_cnt}, (k + 1 > 255) ? 255 : k + 1);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    end
    check("sat_final", {24'd0, lost_cnt}, 32'd255);

    // Randomized: mostly-high lock with drops and occasional resets.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 23) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
